// File: rtl/console_com_ctrl.sv
// -----------------------------------------------------------------------------
// console_com_ctrl
// Handshake controller between the com packet layer and the console/data side.
// It arbitrates received command packets against outgoing send requests. On
// the read path it decodes the packet type into the console operating state
// and an RX channel select. Both paths have cycle timeouts, and the send path
// retries a bounded number of times before reporting a failure.
//
// Optional build macro CONSOLE_COM_ERRCNT_EN adds a saturating 8-bit error
// counter (err_cnt) with a synchronous clear input (err_clr).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   fs_send        upstream send request (level)
//   fd_send        send done (level, held until fs_send falls)
//   fs_read        request to downstream reader (high in READ_WAIT)
//   fd_read        downstream read done
//   fs_com_send    start transmit to com layer (high in SEND_WAIT)
//   fd_com_send    com layer transmit done
//   fs_com_read    com layer has a received packet (level)
//   fd_com_read    received packet consumed (level)
//   com_btype      packet type, valid while fs_com_read is high
//   com_state      operating state: 00 IDLE, 01 CONF, 10 READ
//   rx_sel         RX channel select
//   read_tout      one-cycle pulse on a read timeout
//   send_fail      one-cycle pulse when send retries are exhausted
//   err_clr        (CONSOLE_COM_ERRCNT_EN) synchronous clear of err_cnt
//   err_cnt        (CONSOLE_COM_ERRCNT_EN) saturating error count
// -----------------------------------------------------------------------------
module console_com_ctrl #(
    parameter int unsigned BTYPE_W      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned READ_TIMEOUT = 8'h80,
    parameter int unsigned SEND_TIMEOUT = 8'hF0,
    parameter int unsigned MAX_RETRY    = 2,
    parameter bit          PRIO_READ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fs_send,
    output logic               fd_send,
    output logic               fs_read,
    input  logic               fd_read,
    output logic               fs_com_send,
    input  logic               fd_com_send,
    input  logic               fs_com_read,
    output logic               fd_com_read,
    input  logic [BTYPE_W-1:0] com_btype,
    output logic [1:0]         com_state,
    output logic               rx_sel,
    output logic               read_tout,
    output logic               send_fail
`ifdef CONSOLE_COM_ERRCNT_EN
    ,
    input  logic               err_clr,
    output logic [7:0]         err_cnt
`endif
);

    localparam int unsigned EXT_W = CNT_W + 1;

    // One-hot bit positions; handshake outputs tap these state flops directly
    localparam int unsigned B_MAIN_IDLE  = 0;
    localparam int unsigned B_MAIN_WAIT  = 1;
    localparam int unsigned B_READ_IDLE  = 2;
    localparam int unsigned B_READ_WORK  = 3;
    localparam int unsigned B_READ_WAIT  = 4;
    localparam int unsigned B_READ_DONE  = 5;
    localparam int unsigned B_SEND_IDLE  = 6;
    localparam int unsigned B_SEND_WAIT  = 7;
    localparam int unsigned B_SEND_RETRY = 8;
    localparam int unsigned B_SEND_WORK  = 9;
    localparam int unsigned B_SEND_DONE  = 10;

    typedef enum logic [10:0] {
        MAIN_IDLE  = 11'(1) << B_MAIN_IDLE,
        MAIN_WAIT  = 11'(1) << B_MAIN_WAIT,
        READ_IDLE  = 11'(1) << B_READ_IDLE,
        READ_WORK  = 11'(1) << B_READ_WORK,
        READ_WAIT  = 11'(1) << B_READ_WAIT,
        READ_DONE  = 11'(1) << B_READ_DONE,
        SEND_IDLE  = 11'(1) << B_SEND_IDLE,
        SEND_WAIT  = 11'(1) << B_SEND_WAIT,
        SEND_RETRY = 11'(1) << B_SEND_RETRY,
        SEND_WORK  = 11'(1) << B_SEND_WORK,
        SEND_DONE  = 11'(1) << B_SEND_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       retry;

    // Counter compare done one bit wider so cnt + 1 never wraps
    logic [EXT_W-1:0] cnt_inc;
    logic             read_hit;
    logic             send_hit;

    assign cnt_inc  = EXT_W'(cnt) + EXT_W'(1);
    assign read_hit = (cnt_inc >= EXT_W'(READ_TIMEOUT));
    assign send_hit = (SEND_TIMEOUT != 0) && (cnt_inc >= EXT_W'(SEND_TIMEOUT));

    assign fs_read     = state[B_READ_WAIT];
    assign fd_com_read = state[B_READ_DONE];
    assign fs_com_send = state[B_SEND_WAIT];
    assign fd_send     = state[B_SEND_DONE];

    // Main controller: state, wait counter, retry count, decoded console state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MAIN_IDLE;
            cnt       <= '0;
            retry     <= '0;
            com_state <= 2'b00;
            rx_sel    <= 1'b0;
            read_tout <= 1'b0;
            send_fail <= 1'b0;
        end else begin
            read_tout <= 1'b0;
            send_fail <= 1'b0;
            cnt       <= '0;
            case (state)
                MAIN_IDLE: state <= MAIN_WAIT;
                MAIN_WAIT: begin
                    // A losing request keeps its level and is taken on a later pass
                    if (fs_com_read && fs_send) begin
                        state <= PRIO_READ ? READ_IDLE : SEND_IDLE;
                    end else if (fs_com_read) begin
                        state <= READ_IDLE;
                    end else if (fs_send) begin
                        state <= SEND_IDLE;
                    end
                end
                READ_IDLE: state <= READ_WORK;
                READ_WORK: begin
                    case (com_btype)
                        BTYPE_W'(0): com_state <= 2'b00;
                        BTYPE_W'(1): com_state <= 2'b01;
                        BTYPE_W'(2): com_state <= 2'b10;
                        BTYPE_W'(3): com_state <= 2'b00;
                        BTYPE_W'(4): rx_sel    <= 1'b0;
                        BTYPE_W'(5): rx_sel    <= 1'b1;
                        default: ;
                    endcase
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (fd_read) begin
                        state <= READ_DONE;
                    end else if (read_hit) begin
                        state     <= READ_DONE;
                        read_tout <= 1'b1;
                    end
                end
                READ_DONE: begin
                    if (!fs_com_read) state <= MAIN_WAIT;
                end
                SEND_IDLE: begin
                    retry <= '0;
                    state <= SEND_WAIT;
                end
                SEND_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (fd_com_send) begin
                        state <= SEND_WORK;
                    end else if (send_hit) begin
                        if (retry < 3'(MAX_RETRY)) begin
                            state <= SEND_RETRY;
                        end else begin
                            // Finish with fd_send anyway so upstream never stalls
                            state     <= SEND_DONE;
                            send_fail <= 1'b1;
                        end
                    end
                end
                SEND_RETRY: begin
                    retry <= retry + 3'(1);
                    state <= SEND_WAIT;
                end
                SEND_WORK: state <= SEND_DONE;
                SEND_DONE: begin
                    if (!fs_send) state <= MAIN_WAIT;
                end
                default: state <= MAIN_IDLE;
            endcase
        end
    end

`ifdef CONSOLE_COM_ERRCNT_EN
    // Saturating error counter; clear has priority over a pending increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (err_clr) begin
            err_cnt <= 8'h00;
        end else if ((read_tout || send_fail) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_console_com_ctrl.sv
// -----------------------------------------------------------------------------
// tb_console_com_ctrl
// Self-checking bench for console_com_ctrl. Two instances are used: one with
// read priority and one with send priority. Both use SEND_TIMEOUT=8 and
// MAX_RETRY=2. A select signal routes the stimulus to one instance, and the
// other instance sees idle inputs.
// -----------------------------------------------------------------------------
module tb_console_com_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       fs_send = 1'b0;
    logic       fd_read = 1'b0;
    logic       fd_com_send = 1'b0;
    logic       fs_com_read = 1'b0;
    logic [3:0] com_btype = 4'd0;

    logic       a_fd_send, a_fs_read, a_fs_com_send, a_fd_com_read, a_rx_sel, a_read_tout, a_send_fail;
    logic       b_fd_send, b_fs_read, b_fs_com_send, b_fd_com_read, b_rx_sel, b_read_tout, b_send_fail;
    logic [1:0] a_com_state, b_com_state;

    logic       fd_send, fs_read, fs_com_send, fd_com_read, rx_sel, read_tout, send_fail;
    logic [1:0] com_state;

`ifdef CONSOLE_COM_ERRCNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] a_err_cnt, b_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    console_com_ctrl #(.SEND_TIMEOUT(8), .MAX_RETRY(2), .PRIO_READ(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .fs_send(fs_send & ~sel), .fd_send(a_fd_send),
        .fs_read(a_fs_read), .fd_read(fd_read & ~sel),
        .fs_com_send(a_fs_com_send), .fd_com_send(fd_com_send & ~sel),
        .fs_com_read(fs_com_read & ~sel), .fd_com_read(a_fd_com_read),
        .com_btype(com_btype), .com_state(a_com_state), .rx_sel(a_rx_sel),
        .read_tout(a_read_tout), .send_fail(a_send_fail)
`ifdef CONSOLE_COM_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt(a_err_cnt)
`endif
    );

    console_com_ctrl #(.SEND_TIMEOUT(8), .MAX_RETRY(2), .PRIO_READ(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .fs_send(fs_send & sel), .fd_send(b_fd_send),
        .fs_read(b_fs_read), .fd_read(fd_read & sel),
        .fs_com_send(b_fs_com_send), .fd_com_send(fd_com_send & sel),
        .fs_com_read(fs_com_read & sel), .fd_com_read(b_fd_com_read),
        .com_btype(com_btype), .com_state(b_com_state), .rx_sel(b_rx_sel),
        .read_tout(b_read_tout), .send_fail(b_send_fail)
`ifdef CONSOLE_COM_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt(b_err_cnt)
`endif
    );

    assign fd_send     = sel ? b_fd_send     : a_fd_send;
    assign fs_read     = sel ? b_fs_read     : a_fs_read;
    assign fs_com_send = sel ? b_fs_com_send : a_fs_com_send;
    assign fd_com_read = sel ? b_fd_com_read : a_fd_com_read;
    assign com_state   = sel ? b_com_state   : a_com_state;
    assign rx_sel      = sel ? b_rx_sel      : a_rx_sel;
    assign read_tout   = sel ? b_read_tout   : a_read_tout;
    assign send_fail   = sel ? b_send_fail   : a_send_fail;

    typedef struct {
        logic [3:0] bt;
        int         fd_at;   // READ_WAIT cycle in which fd_read is given, 0 = never
        int         len;
        logic [1:0] st;
        logic       rsel;
        int         tout;
    } rvec_t;

    typedef struct {
        int len;
        logic [1:0] st;
        logic rsel;
        int tout;
    } rexp_t;

    typedef struct {
        int wins;
        int wlen;
        int fail;
    } sexp_t;

    rexp_t rq[$];
    sexp_t sq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one received packet through the read path and score it
    task automatic do_read(input rvec_t v);
        int n, len, touts;
        rexp_t e;
        rq.push_back('{len: v.len, st: v.st, rsel: v.rsel, tout: v.tout});
        @(negedge clk);
        com_btype   = v.bt;
        fs_com_read = 1'b1;
        n = 0;
        while (!fs_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("read_start_bound", int'(n < 20), 1);
        len   = 0;
        touts = 0;
        while (fs_read && len < 400) begin
            len++;
            fd_read = (len == v.fd_at);
            @(negedge clk);
            if (read_tout) touts++;
        end
        fd_read = 1'b0;
        chk("read_done_level", int'(fd_com_read), 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (read_tout) touts++;
            chk("read_done_hold", int'(fd_com_read), 1);
        end
        e = rq.pop_front();
        chk("read_fs_len", len, e.len);
        chk("read_tout_cnt", touts, e.tout);
        chk("read_com_state", int'(com_state), int'(e.st));
        chk("read_rx_sel", int'(rx_sel), int'(e.rsel));
        fs_com_read = 1'b0;
        @(negedge clk);
        chk("read_done_release", int'(fd_com_read), 0);
    endtask

    // Drive one send request; fd_com_send given in cycle fd_at of the first window
    task automatic do_send(input int fd_at, input int exp_wins, input int exp_wlen, input int exp_fail);
        int cyc, wins, wlen, gap, badgap, fails;
        int lens[$];
        logic prev;
        sexp_t e;
        sq.push_back('{wins: exp_wins, wlen: exp_wlen, fail: exp_fail});
        @(negedge clk);
        fs_send = 1'b1;
        cyc = 0; wins = 0; wlen = 0; gap = 0; badgap = 0; fails = 0; prev = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (send_fail) fails++;
            if (fs_com_send) begin
                if (!prev) begin
                    if (wins > 0 && gap != 1) badgap++;
                    wins++;
                    wlen = 0;
                end
                wlen++;
            end else begin
                if (prev) begin
                    lens.push_back(wlen);
                    gap = 0;
                end
                gap++;
            end
            prev = fs_com_send;
            fd_com_send = fs_com_send && (wlen == fd_at) && (wins == 1);
            if (fd_send) break;
        end
        fd_com_send = 1'b0;
        chk("send_done_bound", int'(cyc < 300), 1);
        e = sq.pop_front();
        chk("send_windows", wins, e.wins);
        chk("send_len_count", lens.size(), e.wins);
        foreach (lens[i]) chk("send_window_len", lens[i], e.wlen);
        chk("send_gap_errors", badgap, 0);
        chk("send_fail_cnt", fails, e.fail);
        @(negedge clk);
        chk("send_done_hold", int'(fd_send), 1);
        chk("send_fail_single", int'(send_fail), 0);
        fs_send = 1'b0;
        @(negedge clk);
        chk("send_done_release", int'(fd_send), 0);
    endtask

    // Raise both requests together and record which path starts first
    task automatic prio_run(input logic psel, input logic read_first);
        int fr, fsn, c;
        sel = psel;
        @(negedge clk);
        com_btype   = 4'd1;
        fs_com_read = 1'b1;
        fs_send     = 1'b1;
        fr = -1; fsn = -1;
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (fs_read && fr < 0) fr = c;
            if (fs_com_send && fsn < 0) fsn = c;
            fd_read     = fs_read;
            fd_com_send = fs_com_send;
            if (fd_com_read) fs_com_read = 1'b0;
            if (fd_send) fs_send = 1'b0;
            if (!fs_com_read && !fs_send && !fd_com_read && !fd_send) break;
        end
        fd_read     = 1'b0;
        fd_com_send = 1'b0;
        chk("prio_bound", int'(c < 100), 1);
        chk("prio_read_served", int'(fr >= 0), 1);
        chk("prio_send_served", int'(fsn >= 0), 1);
        chk("prio_order_read_first", int'(fr < fsn), int'(read_first));
        chk("prio_com_state", int'(com_state), 1);
        fs_com_read = 1'b0;
        fs_send     = 1'b0;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fd_send"}, int'(fd_send), 0);
        chk({tag, "_fs_read"}, int'(fs_read), 0);
        chk({tag, "_fs_com_send"}, int'(fs_com_send), 0);
        chk({tag, "_fd_com_read"}, int'(fd_com_read), 0);
        chk({tag, "_com_state"}, int'(com_state), 0);
        chk({tag, "_rx_sel"}, int'(rx_sel), 0);
        chk({tag, "_read_tout"}, int'(read_tout), 0);
        chk({tag, "_send_fail"}, int'(send_fail), 0);
    endtask

    initial begin
        rvec_t vecs[9];
        int n;
        // {btype, fd_at, fs_read cycles, com_state, rx_sel, read_tout pulses}
        vecs[0] = '{4'd2, 5,   5,   2'b10, 1'b0, 0};
        vecs[1] = '{4'd5, 0,   128, 2'b10, 1'b1, 1};
        vecs[2] = '{4'd1, 1,   1,   2'b01, 1'b1, 0};
        vecs[3] = '{4'd4, 3,   3,   2'b01, 1'b0, 0};
        vecs[4] = '{4'd9, 2,   2,   2'b01, 1'b0, 0};
        vecs[5] = '{4'd3, 127, 127, 2'b00, 1'b0, 0};
        vecs[6] = '{4'd0, 128, 128, 2'b00, 1'b0, 0};
        vecs[7] = '{4'd2, 4,   4,   2'b10, 1'b0, 0};
        vecs[8] = '{4'd5, 1,   1,   2'b10, 1'b1, 0};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        foreach (vecs[i]) do_read(vecs[i]);

        do_send(3, 1, 3, 0);
        do_send(0, 3, 8, 1);
        do_send(8, 1, 8, 0);

        prio_run(1'b0, 1'b1);
        prio_run(1'b1, 1'b0);

`ifdef CONSOLE_COM_ERRCNT_EN
        // Earlier read timeout and send failure leave a nonzero count
        chk("errcnt_prior", int'(a_err_cnt), 2);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errcnt_clear", int'(a_err_cnt), 0);
        for (int k = 0; k < 3; k++) do_read('{4'd9, 0, 128, 2'b01, 1'b1, 1});
        @(negedge clk);
        chk("errcnt_three", int'(a_err_cnt), 3);
        err_clr = 1'b1;
        do_read('{4'd9, 0, 128, 2'b01, 1'b1, 1});
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("errcnt_clr_wins", int'(a_err_cnt), 0);
`endif

        // Asynchronous reset while the send path is waiting on the com layer
        @(negedge clk);
        fs_send = 1'b1;
        n = 0;
        while (!fs_com_send && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_send_reached", int'(fs_com_send), 1);
        chk("rst_mid_pre_rx_sel", int'(rx_sel), 1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
`ifdef CONSOLE_COM_ERRCNT_EN
        chk("rst_mid_err_cnt", int'(a_err_cnt), 0);
`endif
        fs_send = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
